speaker_ctl: RTL

Serializes the 16-bit stereo samples from the tone and buzzer generators into a standard I2S stream for the Pmod I2S DAC. It is the sink end of the `audio_left`/`audio_right` sample interface. It derives all DAC clocks (MCLK, LRCK, SCK) from the 100 MHz system clock with one free-running counter. It latches a fresh sample pair once per frame and shifts it out MSB-first, with the standard one-SCK I2S delay.

---
 rtl/speaker_ctl_if.sv | 20 ++
 rtl/speaker_ctl.sv | 40 ++++
 2 files changed

// File: rtl/speaker_ctl_if.sv
// speaker_ctl_if: sample interface from the tone/buzzer source plus the I2S DAC pins
//   master: drives audio_left/audio_right, sees sample_req and the DAC pins
//   slave : speaker_ctl side, consumes samples and drives sample_req and the DAC pins
interface speaker_ctl_if;
  logic [15:0] audio_left;
  logic [15:0] audio_right;
  logic        sample_req;
  logic        audio_mclk;
  logic        audio_lrck;
  logic        audio_sck;
  logic        audio_sdin;
  modport master (
    output audio_left, audio_right,
    input  sample_req, audio_mclk, audio_lrck, audio_sck, audio_sdin
  );
  modport slave (
    input  audio_left, audio_right,
    output sample_req, audio_mclk, audio_lrck, audio_sck, audio_sdin
  );
endinterface

// File: rtl/speaker_ctl.sv
// speaker_ctl: serializes 16-bit stereo samples into an I2S stream for the Pmod I2S DAC
//   clk   : 100 MHz system clock
//   rst_n : asynchronous active-low reset
//   bus   : audio_left/audio_right in, sample_req out, audio_mclk/lrck/sck/sdin to the DAC
module speaker_ctl (
  input  logic          clk,
  input  logic          rst_n,
  speaker_ctl_if.slave  bus
);
  logic [8:0]  cnt_q, cnt_d;
  logic [31:0] sr_q, sr_d;
  logic        sdin_q, sdin_d;
  logic        frame_end, slot_end;
  // The shift register doubles as the sample hold: it is loaded with {L, R} at the
  // frame edge and, after 31 shifts, its MSB holds R[0] for slot 0 of the next frame.
  always_comb begin
    frame_end = cnt_q == 9'd511;
    slot_end  = cnt_q[3:0] == 4'hf;
    cnt_d     = cnt_q + 9'd1;
    sr_d      = frame_end ? {bus.audio_left, bus.audio_right} :
                slot_end  ? {sr_q[30:0], 1'b0} : sr_q;
    sdin_d    = slot_end ? sr_q[31] : sdin_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      sr_q   <= '0;
      sdin_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sr_q   <= sr_d;
      sdin_q <= sdin_d;
    end
  end
  assign bus.audio_mclk = cnt_q[1];
  assign bus.audio_sck  = cnt_q[3];
  assign bus.audio_lrck = cnt_q[8];
  assign bus.audio_sdin = sdin_q;
  assign bus.sample_req = frame_end;
endmodule
